// File: rtl/simproc_pkg.sv
// Shared encodings and widths for the SimProc execution controller.
package simproc_pkg;

    localparam int PC_W        = 8;
    localparam int INSTR_CNT_W = 16;

    typedef enum logic [2:0] {
        RC_HALT  = 3'd0,
        RC_STEP  = 3'd1,
        RC_RUN   = 3'd2,
        RC_CHECK = 3'd3,
        RC_BREAK = 3'd4
    } rc_state_t;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level debounce counter
// and a one-cycle pulse on each accepted falling edge.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_raw,
    output logic key_level,
    output logic key_fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop uses <= so all registers see pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            level_q <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
        end else begin
            sync_a  <= key_raw;
            sync_b  <= sync_a;
            level_d <= level_q;
            if (sync_b == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= sync_b;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign key_level = level_q;
    assign key_fall  = level_d & ~level_q;

endmodule

// File: rtl/run_ctrl.sv
// SimProc execution controller: halt / single-step / divided free-run with
// breakpoint and STOP detection, driving the datapath clock enable.
module run_ctrl
    import simproc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 5000000
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic                   STEP_N,
    input  logic                   RUN,
    input  logic                   BRK_EN,
    input  logic [PC_W-1:0]        BRK_ADDR,
    input  logic [PC_W-1:0]        PC,
    input  logic                   INSTR_DONE,
    input  logic                   HALT_REQ,
    output logic                   CPU_EN,
    output logic [2:0]             STATE,
    output logic                   HALTED,
    output logic                   DISP_EN,
    output logic [INSTR_CNT_W-1:0] INSTR_CNT
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    rc_state_t              state;
    rc_state_t              state_nx;
    logic                   run_a;
    logic                   run_s;
    logic                   key_level;
    logic                   key_fall;
    logic                   press;
    logic                   retire;
    logic                   halt_lat;
    logic                   disp_q;
    logic [DIV_W-1:0]       div_cnt;
    logic [INSTR_CNT_W-1:0] instr_cnt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_key (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .key_raw  (STEP_N),
        .key_level(key_level),
        .key_fall (key_fall)
    );

    assign press  = key_fall & ~key_level;
    assign retire = INSTR_DONE & CPU_EN;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= RC_HALT;
        else       state <= state_nx;
    end

    // NOTE: state_nx gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            RC_HALT:  if (press) state_nx = RC_STEP;
                      else if (run_s) state_nx = RC_RUN;
            RC_STEP:  if (retire) state_nx = RC_HALT;
            RC_RUN:   if (retire) state_nx = RC_CHECK;
            RC_CHECK: if (halt_lat) state_nx = RC_BREAK;
                      else if (BRK_EN && (PC == BRK_ADDR)) state_nx = RC_BREAK;
                      else if (!run_s) state_nx = RC_HALT;
                      else state_nx = RC_RUN;
            RC_BREAK: if (press) state_nx = RC_STEP;
                      else if (!run_s) state_nx = RC_HALT;
            default:  state_nx = RC_HALT;
        endcase
    end

    // Enable decodes registers only, so the datapath sees no input-to-enable path.
    always_comb begin
        CPU_EN  = (state == RC_STEP) || ((state == RC_RUN) && (div_cnt == '0));
        HALTED  = (state == RC_HALT) || (state == RC_BREAK);
        STATE   = state;
        DISP_EN = disp_q;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            run_a     <= 1'b0;
            run_s     <= 1'b0;
            halt_lat  <= 1'b0;
            disp_q    <= 1'b0;
            div_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            run_a  <= RUN;
            run_s  <= run_a;
            disp_q <= (state_nx != state) &&
                      ((state_nx == RC_HALT) || (state_nx == RC_BREAK));
            if (state != RC_RUN || div_cnt == DIV_LAST) div_cnt <= '0;
            else                                        div_cnt <= div_cnt + DIV_W'(1);
            // STOP is only visible alongside INSTR_DONE; hold it for the CHECK cycle.
            if (retire)                 halt_lat <= HALT_REQ;
            else if (state == RC_CHECK) halt_lat <= 1'b0;
            if (retire) instr_cnt <= instr_cnt + INSTR_CNT_W'(1);
        end
    end

    assign INSTR_CNT = instr_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a small multi-cycle CPU model plus a CHECK
// priority vector table and hand-written step/break/run sequences.
module tb_run_ctrl;
    import simproc_pkg::*;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic        RESET = 1'b1;
    logic        STEP_N = 1'b1;
    logic        RUN = 1'b0;
    logic        BRK_EN = 1'b0;
    logic [7:0]  BRK_ADDR = 8'h00;
    logic [7:0]  PC;
    logic        INSTR_DONE;
    logic        HALT_REQ;
    logic        CPU_EN;
    logic [2:0]  STATE;
    logic        HALTED;
    logic        DISP_EN;
    logic [15:0] INSTR_CNT;

    logic        step_n3 = 1'b1;
    logic        run3 = 1'b0;
    logic        brk_en3 = 1'b0;
    logic [7:0]  brk_addr3 = 8'h00;
    logic [7:0]  pc3 = 8'h00;
    logic        instr_done3 = 1'b0;
    logic        halt_req3 = 1'b0;
    logic        cpu_en3;
    logic [2:0]  state3;
    logic        halted3;
    logic        disp_en3;
    logic [15:0] instr_cnt3;

    run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .STEP_N(STEP_N), .RUN(RUN),
        .BRK_EN(BRK_EN), .BRK_ADDR(BRK_ADDR), .PC(PC), .INSTR_DONE(INSTR_DONE),
        .HALT_REQ(HALT_REQ), .CPU_EN(CPU_EN), .STATE(STATE), .HALTED(HALTED),
        .DISP_EN(DISP_EN), .INSTR_CNT(INSTR_CNT)
    );

    run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3)) dut3 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .STEP_N(step_n3), .RUN(run3),
        .BRK_EN(brk_en3), .BRK_ADDR(brk_addr3), .PC(pc3), .INSTR_DONE(instr_done3),
        .HALT_REQ(halt_req3), .CPU_EN(cpu_en3), .STATE(state3), .HALTED(halted3),
        .DISP_EN(disp_en3), .INSTR_CNT(instr_cnt3)
    );

    // CPU model: each instruction takes cpi enabled cycles, PC advances on retire.
    int         cpi = 4;
    int         hreq_at = 0;
    logic       model_on = 1'b0;
    logic [7:0] pc_init = 8'h00;
    logic [7:0] model_pc = 8'h00;
    int         phase = 0;
    int         model_ret = 0;

    always @(posedge CLOCK_50) begin
        if (!model_on) begin
            phase     <= 0;
            model_ret <= 0;
            model_pc  <= pc_init;
        end else if (CPU_EN) begin
            if (phase == cpi - 1) begin
                phase     <= 0;
                model_ret <= model_ret + 1;
                model_pc  <= model_pc + 8'd1;
            end else begin
                phase <= phase + 1;
            end
        end
    end

    assign PC         = model_pc;
    assign INSTR_DONE = model_on && (phase == cpi - 1);
    assign HALT_REQ   = model_on && (hreq_at != 0) && (model_ret == hreq_at - 1);

    int en_cnt = 0;
    int disp_cnt = 0;
    always @(posedge CLOCK_50) begin
        if (CPU_EN === 1'b1)  en_cnt   <= en_cnt + 1;
        if (DISP_EN === 1'b1) disp_cnt <= disp_cnt + 1;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int i;
        i = 0;
        while (STATE !== s && i < budget) begin
            tick();
            i++;
        end
        check(name, {29'd0, STATE}, {29'd0, s});
    endtask

    task automatic do_reset();
        model_on = 1'b0;
        RUN = 1'b0;
        STEP_N = 1'b1;
        run3 = 1'b0;
        instr_done3 = 1'b0;
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick();
    endtask

    typedef struct {
        logic       hreq;
        logic       brk_en;
        logic [7:0] pc;
        logic [7:0] addr;
        logic       run;
        logic [2:0] exp_state;
        logic       exp_halted;
        logic       exp_disp;
    } chk_vec_t;

    chk_vec_t vecs[6];
    int       e0;
    int       d0;
    int       i3;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'h10, 8'h10, 1'b1, RC_BREAK, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 8'h22, 8'h22, 1'b0, RC_BREAK, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'h33, 8'h33, 1'b1, RC_RUN,   1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h44, 8'h45, 1'b0, RC_HALT,  1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h50, 8'h00, 1'b0, RC_BREAK, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'h60, 8'h61, 1'b1, RC_RUN,   1'b0, 1'b0};

        // Reset values and quiet idle.
        tick(2);
        check("rst_state", {29'd0, STATE}, 32'd0);
        check("rst_cpu_en", {31'd0, CPU_EN}, 32'd0);
        check("rst_halted", {31'd0, HALTED}, 32'd1);
        check("rst_instr_cnt", {16'd0, INSTR_CNT}, 32'd0);
        d0 = disp_cnt;
        RESET = 1'b0;
        tick(20);
        check("idle_state", {29'd0, STATE}, 32'd0);
        check("idle_cpu_en", {31'd0, CPU_EN}, 32'd0);
        check("idle_halted", {31'd0, HALTED}, 32'd1);
        check("idle_instr_cnt", {16'd0, INSTR_CNT}, 32'd0);
        check("idle_disp_pulses", disp_cnt - d0, 32'd0);

        // Single step: one 4-cycle instruction per press.
        cpi = 4;
        hreq_at = 0;
        model_on = 1'b1;
        e0 = en_cnt;
        d0 = disp_cnt;
        STEP_N = 1'b0;
        tick(10);
        STEP_N = 1'b1;
        tick(20);
        check("step_en_cycles", en_cnt - e0, 32'd4);
        check("step_instr_cnt", {16'd0, INSTR_CNT}, 32'd1);
        check("step_state", {29'd0, STATE}, {29'd0, RC_HALT});
        check("step_disp_pulses", disp_cnt - d0, 32'd1);

        // Two-cycle glitch must be rejected.
        e0 = en_cnt;
        STEP_N = 1'b0;
        tick(2);
        STEP_N = 1'b1;
        tick(15);
        check("glitch_state", {29'd0, STATE}, {29'd0, RC_HALT});
        check("glitch_en_cycles", en_cnt - e0, 32'd0);
        check("glitch_instr_cnt", {16'd0, INSTR_CNT}, 32'd1);

        // CHECK-cycle priority table: one instruction in RUN, then inspect the decision.
        for (int v = 0; v < 6; v++) begin
            cpi = 4;
            hreq_at = vecs[v].hreq ? 1 : 0;
            pc_init = vecs[v].pc - 8'd1;
            BRK_EN = vecs[v].brk_en;
            BRK_ADDR = vecs[v].addr;
            do_reset();
            model_on = 1'b1;
            RUN = 1'b1;
            wait_state(RC_RUN, 10, $sformatf("vec%0d_enter_run", v));
            if (!vecs[v].run) RUN = 1'b0;
            wait_state(RC_CHECK, 10, $sformatf("vec%0d_reach_check", v));
            check($sformatf("vec%0d_check_cpu_en", v), {31'd0, CPU_EN}, 32'd0);
            tick();
            check($sformatf("vec%0d_state", v), {29'd0, STATE}, {29'd0, vecs[v].exp_state});
            check($sformatf("vec%0d_halted", v), {31'd0, HALTED}, {31'd0, vecs[v].exp_halted});
            check($sformatf("vec%0d_disp_en", v), {31'd0, DISP_EN}, {31'd0, vecs[v].exp_disp});
            check($sformatf("vec%0d_instr_cnt", v), {16'd0, INSTR_CNT}, 32'd1);
        end

        // Breakpoint at 0x05, then a press steps one instruction and RUN resumes.
        cpi = 3;
        hreq_at = 0;
        pc_init = 8'h00;
        BRK_EN = 1'b1;
        BRK_ADDR = 8'h05;
        do_reset();
        model_on = 1'b1;
        RUN = 1'b1;
        wait_state(RC_BREAK, 60, "brk_enter");
        check("brk_instr_cnt", {16'd0, INSTR_CNT}, 32'd5);
        check("brk_pc", {24'd0, PC}, 32'h05);
        check("brk_disp_en", {31'd0, DISP_EN}, 32'd1);
        tick(5);
        check("brk_hold", {29'd0, STATE}, {29'd0, RC_BREAK});
        check("brk_hold_cpu_en", {31'd0, CPU_EN}, 32'd0);
        STEP_N = 1'b0;
        wait_state(RC_STEP, 20, "brk_press_step");
        STEP_N = 1'b1;
        wait_state(RC_HALT, 10, "brk_step_halt");
        check("brk_step_pc", {24'd0, PC}, 32'h06);
        check("brk_step_instr_cnt", {16'd0, INSTR_CNT}, 32'd6);
        tick();
        check("brk_resume_run", {29'd0, STATE}, {29'd0, RC_RUN});
        BRK_EN = 1'b0;

        // STOP opcode on the 3rd instruction, then RUN off returns to HALT.
        cpi = 3;
        hreq_at = 3;
        pc_init = 8'h40;
        do_reset();
        model_on = 1'b1;
        RUN = 1'b1;
        wait_state(RC_BREAK, 60, "stop_enter_break");
        check("stop_instr_cnt", {16'd0, INSTR_CNT}, 32'd3);
        check("stop_disp_en", {31'd0, DISP_EN}, 32'd1);
        RUN = 1'b0;
        wait_state(RC_HALT, 10, "stop_run_off_halt");
        check("stop_halted", {31'd0, HALTED}, 32'd1);

        // RUN_DIV=3: enable pattern, and RUN dropped mid-instruction.
        do_reset();
        run3 = 1'b1;
        i3 = 0;
        while (state3 !== RC_RUN && i3 < 10) begin
            tick();
            i3++;
        end
        check("div3_enter_run", {29'd0, state3}, {29'd0, RC_RUN});
        for (int k = 0; k < 6; k++) begin
            check($sformatf("div3_en_%0d", k), {31'd0, cpu_en3}, (k % 3 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        run3 = 1'b0;
        tick(5);
        check("div3_still_run", {29'd0, state3}, {29'd0, RC_RUN});
        instr_done3 = 1'b1;
        i3 = 0;
        while (state3 !== RC_CHECK && i3 < 6) begin
            tick();
            i3++;
        end
        instr_done3 = 1'b0;
        check("div3_check", {29'd0, state3}, {29'd0, RC_CHECK});
        check("div3_instr_cnt", {16'd0, instr_cnt3}, 32'd1);
        tick();
        check("div3_halt", {29'd0, state3}, {29'd0, RC_HALT});

        // Counter wrap from 0xFFFF.
        model_on = 1'b0;
        hreq_at = 0;
        cpi = 1;
        tick();
        model_on = 1'b1;
        force dut.instr_cnt = 16'hFFFF;
        tick();
        release dut.instr_cnt;
        tick();
        check("wrap_preload", {16'd0, INSTR_CNT}, 32'h0000FFFF);
        STEP_N = 1'b0;
        wait_state(RC_STEP, 20, "wrap_step");
        STEP_N = 1'b1;
        tick();
        check("wrap_instr_cnt", {16'd0, INSTR_CNT}, 32'd0);
        check("wrap_state", {29'd0, STATE}, {29'd0, RC_HALT});

        // Asynchronous reset in the middle of a long instruction.
        model_on = 1'b0;
        cpi = 20;
        tick();
        model_on = 1'b1;
        RUN = 1'b1;
        wait_state(RC_RUN, 10, "arst_enter_run");
        tick(2);
        RESET = 1'b1;
        #1;
        check("arst_state", {29'd0, STATE}, 32'd0);
        check("arst_cpu_en", {31'd0, CPU_EN}, 32'd0);
        check("arst_halted", {31'd0, HALTED}, 32'd1);
        RUN = 1'b0;
        model_on = 1'b0;
        tick();
        d0 = disp_cnt;
        RESET = 1'b0;
        tick(3);
        check("arst_release_disp", disp_cnt - d0, 32'd0);
        check("arst_instr_cnt", {16'd0, INSTR_CNT}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
